// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: mode sets, sync polarity encodings and the
// registered sync bundle carried through the alignment delay.
package vga_timing_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int unsigned VGA_640X480_H_ACTIVE = 640;
  localparam int unsigned VGA_640X480_H_FP     = 16;
  localparam int unsigned VGA_640X480_H_SYNC   = 96;
  localparam int unsigned VGA_640X480_H_BP     = 48;
  localparam int unsigned VGA_640X480_V_ACTIVE = 480;
  localparam int unsigned VGA_640X480_V_FP     = 10;
  localparam int unsigned VGA_640X480_V_SYNC   = 2;
  localparam int unsigned VGA_640X480_V_BP     = 33;

  // 800x600@60, 40 MHz pixel clock; H_TOTAL 1056 needs an 11-bit counter
  localparam int unsigned VGA_800X600_H_ACTIVE = 800;
  localparam int unsigned VGA_800X600_H_FP     = 40;
  localparam int unsigned VGA_800X600_H_SYNC   = 128;
  localparam int unsigned VGA_800X600_H_BP     = 88;
  localparam int unsigned VGA_800X600_V_ACTIVE = 600;
  localparam int unsigned VGA_800X600_V_FP     = 1;
  localparam int unsigned VGA_800X600_V_SYNC   = 4;
  localparam int unsigned VGA_800X600_V_BP     = 23;

  localparam int unsigned VGA_CNT_W = 10;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Sync fields hold "asserted" (1) / "not asserted" (0); polarity is applied at the pins.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } vga_sync_t;

  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH x WIDTH shift register advanced by ce, cleared by a synchronous reset.
// DEPTH = 0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, reset_i, ce_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          stage_q[i] <= '0;
        end
      end else if (ce_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters advanced by pix_ce,
// registered coordinates, active-video and sync with optional pipeline alignment.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_640X480_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_640X480_H_FP,
  parameter int unsigned H_SYNC     = VGA_640X480_H_SYNC,
  parameter int unsigned H_BP       = VGA_640X480_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_640X480_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_640X480_V_FP,
  parameter int unsigned V_SYNC     = VGA_640X480_V_SYNC,
  parameter int unsigned V_BP       = VGA_640X480_V_BP,
  parameter logic        H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic        V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned SYNC_DELAY = 0,
  parameter int unsigned CNT_W      = VGA_CNT_W
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] countX,
  output logic [CNT_W-1:0] countY,
  output logic             displayArea,
  output logic             hSync,
  output logic             vSync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  vga_sync_t        sync_d, sync_q, sync_dly;
  logic             line_start_d, frame_start_d;

  // Raster advance, sync decode and strobe detection on the internal count
  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    sync_d        = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pix_ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_ONE;
      end else begin
        hc_d = hc_q + CNT_ONE;
      end
      line_start_d  = (hc_q == '0);
      frame_start_d = (hc_q == '0) && (vc_q == '0);
    end

    sync_d.act = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
    sync_d.hs  = (hc_q >= HS_BEG) && (hc_q < HS_END);
    sync_d.vs  = (vc_q >= VS_BEG) && (vc_q < VS_END);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q        <= '0;
      vc_q        <= '0;
      countX      <= '0;
      countY      <= '0;
      sync_q      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      if (pix_ce) begin
        countX <= hc_q;
        countY <= vc_q;
        sync_q <= sync_d;
      end
    end
  end

  // Re-aligns active video and syncs with a pipelined pixel path; strobes bypass it
  vga_delay_line #(
    .DEPTH(SYNC_DELAY),
    .WIDTH($bits(vga_sync_t))
  ) u_sync_dly (
    .clk_i  (vga_clk),
    .reset_i(reset),
    .ce_i   (pix_ce),
    .d_i    (sync_q),
    .q_o    (sync_dly)
  );

  assign displayArea = sync_dly.act;
  assign hSync       = sync_dly.hs ? H_SYNC_POL : ~H_SYNC_POL;
  assign vSync       = sync_dly.vs ? V_SYNC_POL : ~V_SYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a small-raster instance and a default-raster instance with
// SYNC_DELAY=2 / active-high hSync, both checked every cycle against a linear-index model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ce = 1'b0;
  logic chk_en = 1'b0;

  logic [9:0] countX_a, countY_a, countX_b, countY_b;
  logic da_a, hs_a, vs_a, ls_a, fs_a;
  logic da_b, hs_b, vs_b, ls_b, fs_b;

  int tests = 0;
  int errors = 0;

  // Model state: pixels emitted since reset, and whether the last edge was a ce edge
  longint n_ce = 0;
  bit     last_ce = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .SYNC_DELAY(0), .CNT_W(10)
  ) u_dut_a (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .countX(countX_a), .countY(countY_a), .displayArea(da_a),
    .hSync(hs_a), .vSync(vs_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_SYNC_POL(1'b1), .SYNC_DELAY(2)
  ) u_dut_b (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .countX(countX_b), .countY(countY_b), .displayArea(da_b),
    .hSync(hs_b), .vSync(vs_b), .line_start(ls_b), .frame_start(fs_b)
  );

  typedef struct {
    int x; int y; bit da; bit hs; bit vs; bit ls; bit fs;
  } exp_t;

  // Output n pixels after reset: coordinates of pixel n-1, sync of pixel n-1-dly
  function automatic exp_t model(input int ht, input int vt, input int ha, input int va,
                                 input int hsb, input int hse, input int vsb, input int vse,
                                 input int dly, input bit hpol, input bit vpol,
                                 input longint n, input bit ce_edge);
    exp_t e;
    longint idx, di;
    int dx, dy;
    e.x = 0; e.y = 0; e.da = 1'b0; e.hs = ~hpol; e.vs = ~vpol; e.ls = 1'b0; e.fs = 1'b0;
    if (n > 0) begin
      idx  = n - 1;
      e.x  = int'(idx % ht);
      e.y  = int'((idx / ht) % vt);
      e.ls = ce_edge && (e.x == 0);
      e.fs = e.ls && (e.y == 0);
      if (idx >= dly) begin
        di   = idx - dly;
        dx   = int'(di % ht);
        dy   = int'((di / ht) % vt);
        e.da = (dx < ha) && (dy < va);
        e.hs = (dx >= hsb && dx < hse) ? hpol : ~hpol;
        e.vs = (dy >= vsb && dy < vse) ? vpol : ~vpol;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      n_ce    = 0;
      last_ce = 1'b0;
    end else begin
      last_ce = pix_ce;
      if (pix_ce) n_ce++;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    exp_t ea, eb;
    if (chk_en) begin
      ea = model(25, 19, 16, 12, 18, 22, 14, 16, 0, 1'b0, 1'b0, n_ce, last_ce);
      eb = model(800, 525, 640, 480, 656, 752, 490, 492, 2, 1'b1, 1'b0, n_ce, last_ce);
      chk("a_countX", longint'(countX_a), ea.x);
      chk("a_countY", longint'(countY_a), ea.y);
      chk("a_displayArea", longint'(da_a), ea.da);
      chk("a_hSync", longint'(hs_a), ea.hs);
      chk("a_vSync", longint'(vs_a), ea.vs);
      chk("a_line_start", longint'(ls_a), ea.ls);
      chk("a_frame_start", longint'(fs_a), ea.fs);
      chk("b_countX", longint'(countX_b), eb.x);
      chk("b_countY", longint'(countY_b), eb.y);
      chk("b_displayArea", longint'(da_b), eb.da);
      chk("b_hSync", longint'(hs_b), eb.hs);
      chk("b_vSync", longint'(vs_b), eb.vs);
      chk("b_line_start", longint'(ls_b), eb.ls);
      chk("b_frame_start", longint'(fs_b), eb.fs);
    end
  end

  initial begin
    int fs_cnt, hs_low, fs_k0, fs_k1;
    bit found;

    // Reset with ce low
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_countX_a", longint'(countX_a), 0);
    chk("rst_da_a", longint'(da_a), 0);
    chk("rst_hSync_a", longint'(hs_a), 1);
    chk("rst_hSync_b", longint'(hs_b), 0);
    chk("rst_vSync_b", longint'(vs_b), 1);
    chk("rst_line_start_a", longint'(ls_a), 0);

    // Free run, pix_ce = 1; at step k countX = k-1
    reset = 1'b0; pix_ce = 1'b1;
    fs_cnt = 0; hs_low = 0; fs_k0 = -1; fs_k1 = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (fs_a) begin
        fs_cnt++;
        if (fs_k0 < 0) fs_k0 = k; else if (fs_k1 < 0) fs_k1 = k;
      end
      if (k <= 25 && !hs_a) hs_low++;
      case (k)
        1: begin
          chk("first_ls_a", longint'(ls_a), 1);
          chk("first_fs_a", longint'(fs_a), 1);
          chk("first_fs_b", longint'(fs_b), 1);
          chk("first_countX_b", longint'(countX_b), 0);
        end
        2: begin
          chk("ls_a_width", longint'(ls_a), 0);
          chk("b_da_x1", longint'(da_b), 0);
        end
        3:   chk("b_da_x2", longint'(da_b), 1);
        475: begin
          chk("a_last_x", longint'(countX_a), 24);
          chk("a_last_y", longint'(countY_a), 18);
        end
        476: chk("a_wrap_y", longint'(countY_a), 0);
        658: chk("b_hs_x657", longint'(hs_b), 0);
        659: chk("b_hs_x658", longint'(hs_b), 1);
        754: chk("b_hs_x753", longint'(hs_b), 1);
        755: chk("b_hs_x754", longint'(hs_b), 0);
        801: begin
          chk("b_ls_row1", longint'(ls_b), 1);
          chk("b_row1_y", longint'(countY_b), 1);
        end
        default: ;
      endcase
    end
    chk("a_fs_count", fs_cnt, 3);
    chk("a_fs_period", fs_k1 - fs_k0, 475);
    chk("a_hs_low_per_line", hs_low, 4);

    // pix_ce one-in-four: frame period 4x
    reset = 1'b1; pix_ce = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    fs_k0 = -1; fs_k1 = -1;
    for (int i = 0; i < 4000; i++) begin
      pix_ce = (i % 4 == 0);
      @(negedge clk);
      if (fs_a) begin
        if (fs_k0 < 0) fs_k0 = i; else if (fs_k1 < 0) fs_k1 = i;
      end
    end
    chk("a_fs_period_ce4", fs_k1 - fs_k0, 1900);

    // Mid-frame reset with pix_ce high in the same cycle
    pix_ce = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (countX_a == 10'd10 && countY_a == 10'd5) found = 1'b1;
    end
    chk("reach_x10_y5", longint'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_countX_a", longint'(countX_a), 0);
    chk("midrst_countY_a", longint'(countY_a), 0);
    chk("midrst_hSync_a", longint'(hs_a), 1);
    chk("midrst_vSync_a", longint'(vs_a), 1);
    chk("midrst_da_a", longint'(da_a), 0);
    @(negedge clk);
    reset = 1'b0; pix_ce = 1'b0;
    repeat (3) @(negedge clk);
    pix_ce = 1'b1;
    @(negedge clk);
    chk("post_rst_fs_a", longint'(fs_a), 1);
    chk("post_rst_ls_b", longint'(ls_b), 1);

    // Randomised ce density with occasional resets
    for (int i = 0; i < 15000; i++) begin
      case ((i / 1500) % 3)
        0:       pix_ce = ($urandom_range(0, 3) != 0);
        1:       pix_ce = ($urandom_range(0, 3) == 0);
        default: pix_ce = 1'b1;
      endcase
      reset = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
